// File: rtl/shift_pkg.sv
// Shared encodings for the shift sweep controller and the barrel shifter top level.
package shift_pkg;

  localparam int unsigned REP_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SWEEP_L = 2'd1,
    SWEEP_R = 2'd2
  } state_t;

  localparam logic DIR_MSB = 1'b1;
  localparam logic DIR_LSB = 1'b0;

endpackage

// File: rtl/mod_m_counter.sv
// Free-running modulo-M counter with synchronous clear; max_tick flags the last count.
module mod_m_counter #(
  parameter int unsigned M = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic max_tick
);

  localparam int unsigned W = $clog2(M);

  logic [W-1:0] count;

  assign max_tick = (count == W'(M - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (max_tick) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/shift_sweep_ctrl.sv
// Timed shift-amount sweep generator: walks shamt 0..2^N-1 toward MSB, then toward LSB,
// for a programmed number of repetitions (0 = continuous).
module shift_sweep_ctrl
  import shift_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned PRESC = 25_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [(1<<N)-1:0]   pattern_in,
  input  logic [REP_W-1:0]    reps_in,
  output logic [(1<<N)-1:0]   pattern_out,
  output logic [N-1:0]        shamt,
  output logic                dir,
  output logic                busy,
  output logic                done
);

  localparam int unsigned W_DATA = 1 << N;
  localparam logic [N-1:0] SHAMT_MAX = {N{1'b1}};

  state_t            state, state_n;
  logic [N-1:0]      shamt_n;
  logic [W_DATA-1:0] pattern_n;
  logic [REP_W-1:0]  reps, reps_n;
  logic [REP_W-1:0]  rep_cnt, rep_cnt_n;
  logic [REP_W-1:0]  rep_inc;
  logic              done_n;
  logic              tick;
  logic              presc_clr;

  // Prescaler idles at zero outside a sweep so the first dwell is a full PRESC cycles.
  assign presc_clr = stop || (state == IDLE);

  mod_m_counter #(.M(PRESC)) u_presc (
    .clk      (clk),
    .reset    (reset),
    .clr      (presc_clr),
    .max_tick (tick)
  );

  assign rep_inc = REP_W'(rep_cnt + REP_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shamt       <= '0;
      pattern_out <= '0;
      reps        <= '0;
      rep_cnt     <= '0;
      dir         <= DIR_MSB;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      shamt       <= shamt_n;
      pattern_out <= pattern_n;
      reps        <= reps_n;
      rep_cnt     <= rep_cnt_n;
      dir         <= (state_n == SWEEP_R) ? DIR_LSB : DIR_MSB;
      busy        <= (state_n != IDLE);
      done        <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    shamt_n   = shamt;
    pattern_n = pattern_out;
    reps_n    = reps;
    rep_cnt_n = rep_cnt;
    done_n    = 1'b0;

    if (stop) begin
      state_n = IDLE;
      shamt_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          shamt_n = '0;
          if (start) begin
            pattern_n = pattern_in;
            reps_n    = reps_in;
            rep_cnt_n = '0;
            state_n   = SWEEP_L;
          end
        end
        SWEEP_L: begin
          if (tick) begin
            if (shamt != SHAMT_MAX) begin
              shamt_n = shamt + N'(1);
            end else begin
              shamt_n = '0;
              state_n = SWEEP_R;
            end
          end
        end
        SWEEP_R: begin
          if (tick) begin
            if (shamt != SHAMT_MAX) begin
              shamt_n = shamt + N'(1);
            end else begin
              shamt_n = '0;
              state_n = SWEEP_L;
              // A zero repetition count never terminates on its own.
              if (reps != '0) begin
                rep_cnt_n = rep_inc;
                if (rep_inc == reps) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
                end
              end
            end
          end
        end
        default: begin
          state_n = IDLE;
          shamt_n = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sweep_ctrl.sv
// Scoreboard bench for shift_sweep_ctrl with N=3, PRESC=4.
module tb_shift_sweep_ctrl;

  localparam int unsigned N     = 3;
  localparam int unsigned PRESC = 4;
  localparam int unsigned SWEEP = 2 * 8 * PRESC;

  typedef struct packed {
    logic [7:0] pat;
    logic [2:0] shamt;
    logic       dir;
    logic       busy;
    logic       done;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic [7:0] pattern_in;
  logic [3:0] reps_in;
  logic [7:0] pattern_out;
  logic [2:0] shamt;
  logic       dir;
  logic       busy;
  logic       done;

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t sb[$];
  obs_t got, want;

  shift_sweep_ctrl #(.N(N), .PRESC(PRESC)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .pattern_in  (pattern_in),
    .reps_in     (reps_in),
    .pattern_out (pattern_out),
    .shamt       (shamt),
    .dir         (dir),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    return {pattern_out, shamt, dir, busy, done};
  endfunction

  function automatic obs_t idle_state(input logic [7:0] pat, input logic d);
    obs_t o;
    o.pat = pat; o.shamt = 3'd0; o.dir = 1'b1; o.busy = 1'b0; o.done = d;
    return o;
  endfunction

  // Expected outputs for cycle k after the start edge, derived from dwell/pass lengths.
  function automatic obs_t sweep_state(input logic [7:0] pat, input int k);
    obs_t o;
    int s;
    s       = k % SWEEP;
    o.pat   = pat;
    o.dir   = (s < SWEEP / 2);
    o.shamt = 3'((s % (SWEEP / 2)) / PRESC);
    o.busy  = 1'b1;
    o.done  = 1'b0;
    return o;
  endfunction

  // Push a finite run: reps sweeps, then the done cycle, then one quiet idle cycle.
  task automatic push_finite(input logic [7:0] pat, input int reps);
    for (int k = 0; k < reps * SWEEP; k++) sb.push_back(sweep_state(pat, k));
    sb.push_back(idle_state(pat, 1'b1));
    sb.push_back(idle_state(pat, 1'b0));
  endtask

  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; pattern_in = 8'hA5; reps_in = 4'd1;
    repeat (3) tick_edge();
    reset = 1'b0;
    tick_edge();
    got  = observe();
    want = idle_state(8'h00, 1'b0);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset: got %h expected %h", got, want);
    end
  endtask

  task automatic test_single_sweep();
    pattern_in = 8'h01; reps_in = 4'd1;
    push_finite(8'h01, 1);
    start = 1'b1;
    while (sb.size() > 0) begin
      tick_edge();
      start = 1'b0;
      got  = observe();
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL single_sweep: got %h expected %h", got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    pattern_in = 8'h81; reps_in = 4'd2;
    push_finite(8'h81, 2);
    start = 1'b1;
    while (sb.size() > 0) begin
      tick_edge();
      start = 1'b0;
      got  = observe();
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL back_to_back: got %h expected %h", got, want);
      end
    end
  endtask

  task automatic test_start_ignored();
    int i;
    pattern_in = 8'h01; reps_in = 4'd1;
    push_finite(8'h01, 1);
    start = 1'b1;
    i = 0;
    while (sb.size() > 0) begin
      tick_edge();
      start = 1'b0;
      // Re-pulse with new data once in SWEEP_L and once in SWEEP_R.
      if (i == 9 || i == 40) begin
        start = 1'b1; pattern_in = 8'hF0; reps_in = 4'd3;
      end
      got  = observe();
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL start_ignored: cycle %0d got %h expected %h", i, got, want);
      end
      i++;
    end
    start = 1'b0;
  endtask

  task automatic test_continuous_stop();
    localparam int STOP_K = 8 * SWEEP + SWEEP / 2 + 5 * PRESC;
    pattern_in = 8'h5A; reps_in = 4'd0;
    for (int k = 0; k <= STOP_K; k++) sb.push_back(sweep_state(8'h5A, k));
    start = 1'b1;
    while (sb.size() > 0) begin
      tick_edge();
      start = 1'b0;
      got  = observe();
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL continuous: got %h expected %h", got, want);
      end
    end
    stop = 1'b1;
    for (int k = 0; k < 4; k++) sb.push_back(idle_state(8'h5A, 1'b0));
    while (sb.size() > 0) begin
      tick_edge();
      stop = 1'b0;
      got  = observe();
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL stop_mid_sweep: got %h expected %h", got, want);
      end
    end
  endtask

  task automatic test_start_stop_reset();
    pattern_in = 8'hAA; reps_in = 4'd1;
    start = 1'b1; stop = 1'b1;
    sb.push_back(idle_state(8'h5A, 1'b0));
    sb.push_back(idle_state(8'h5A, 1'b0));
    while (sb.size() > 0) begin
      tick_edge();
      start = 1'b0; stop = 1'b0;
      got  = observe();
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL start_and_stop: got %h expected %h", got, want);
      end
    end
    pattern_in = 8'h3C;
    for (int k = 0; k < 10; k++) sb.push_back(sweep_state(8'h3C, k));
    start = 1'b1;
    while (sb.size() > 0) begin
      tick_edge();
      start = 1'b0;
      got  = observe();
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL pre_reset_sweep: got %h expected %h", got, want);
      end
    end
    reset = 1'b1;
    sb.push_back(idle_state(8'h00, 1'b0));
    sb.push_back(idle_state(8'h00, 1'b0));
    sb.push_back(idle_state(8'h00, 1'b0));
    while (sb.size() > 0) begin
      tick_edge();
      reset = 1'b0;
      got  = observe();
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset_mid_sweep: got %h expected %h", got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_sweep();
    test_back_to_back();
    test_start_ignored();
    test_continuous_stop();
    test_start_stop_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
